// File: rtl/recon_pkg.sv
// recon_pkg
//   Shared definitions for the partial-reconfiguration datapath: FSM state
//   encodings, status error codes, per-byte bit reversal for the ICAP port,
//   and tkeep qualification helpers (contiguity and popcount). The recon
//   controller uses the same helpers when it builds DMA descriptors.
package recon_pkg;

  // FSM state encodings (plain constants so older tooling can consume them)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Status error codes
  localparam logic [1:0] ERR_OK    = 2'b00;  // delivered length matched
  localparam logic [1:0] ERR_SHORT = 2'b01;  // tlast before commanded length
  localparam logic [1:0] ERR_LONG  = 2'b10;  // stream carried more than commanded
  localparam logic [1:0] ERR_KEEP  = 2'b11;  // tkeep not contiguous / not word multiple

  // Widest tkeep the helpers handle (DATA_WIDTH up to 1024 bits). Narrower
  // keeps are zero-extended by the caller.
  localparam int KEEP_MAX = 128;

  // Reverse bit order within one byte (ICAP expects bit-swapped bytes).
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Number of enabled bytes.
  function automatic logic [7:0] keep_popcount(input logic [KEEP_MAX-1:0] k);
    logic [7:0] pc;
    pc = '0;
    for (int i = 0; i < KEEP_MAX; i++) pc = pc + 8'(k[i]);
    return pc;
  endfunction

  // Keep is usable when it is a run of ones starting at bit 0 and covers a
  // whole number of 32-bit words. k & (k+1) is zero only for 0...01...1.
  function automatic logic keep_ok(input logic [KEEP_MAX-1:0] k);
    logic [KEEP_MAX-1:0] k1;
    logic [7:0]          pc;
    k1 = k + KEEP_MAX'(1);
    pc = keep_popcount(k);
    return ((k & k1) == '0) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/icap_stream_writer.sv
// icap_stream_writer
//   Consumes one length command, then serialises wide AXI-Stream beats of
//   partial bitstream into 32-bit ICAP writes. Delivered length is checked
//   against the commanded length; malformed frames are drained to tlast and
//   one status word is pulsed per command.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   s_cmd_*                byte length command (low two bits ignored)
//   s_axis_*               bitstream stream, byte 0 in tdata[7:0]
//   icap_csib/rdwrb/i      ICAP write port (registered), icap_avail = ready
//   m_status_*             words written + error code, one-cycle valid pulse
//   busy                   high whenever a command is in progress
module icap_stream_writer
  import recon_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int LEN_WIDTH  = 20,
  parameter bit BIT_SWAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  s_cmd_len,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  icap_csib,
  output logic                  icap_rdwrb,
  output logic [31:0]           icap_i,
  input  logic                  icap_avail,
  output logic [LEN_WIDTH-3:0]  m_status_words,
  output logic [1:0]            m_status_error,
  output logic                  m_status_valid,
  output logic                  busy
);

  localparam int BEAT_WORDS = DATA_WIDTH/32;
  localparam int BW_W       = $clog2(BEAT_WORDS+1);
  localparam int SW_W       = LEN_WIDTH-2;

  logic [2:0]            state;
  logic [LEN_WIDTH-1:0]  remaining;   // bytes still expected, always word multiple
  logic [SW_W-1:0]       words;       // words written for this command
  logic [1:0]            err;
  logic [DATA_WIDTH-1:0] shreg;       // current beat, word 0 at the bottom
  logic [BW_W-1:0]       beat_words;  // words of the current beat not yet emitted
  logic                  beat_last;   // current beat carried tlast

  logic                  cmd_fire, beat_fire;
  logic [KEEP_MAX-1:0]   keep_ext;
  logic [7:0]            keep_pc;
  logic                  emit;
  logic [LEN_WIDTH-1:0]  rem_after;
  logic [LEN_WIDTH-1:0]  rem_eval;
  logic                  end_beat;
  logic                  overrun;
  logic [31:0]           emit_word;

  assign s_cmd_ready    = (state == ST_IDLE) && !rst;
  assign s_axis_tready  = ((state == ST_LOAD) || (state == ST_FLUSH)) && !rst;
  assign m_status_valid = (state == ST_DONE) && !rst;
  assign m_status_words = words;
  assign m_status_error = err;
  assign busy           = (state != ST_IDLE);
  assign icap_rdwrb     = 1'b0;

  assign cmd_fire  = s_cmd_valid && s_cmd_ready;
  assign beat_fire = s_axis_tvalid && s_axis_tready;

  always_comb begin
    keep_ext = '0;
    keep_ext[KEEP_WIDTH-1:0] = s_axis_tkeep;
  end
  assign keep_pc = keep_popcount(keep_ext);

  // While in SHIFT with words left, remaining is always non-zero: a beat is
  // only loaded with remaining > 0 and the state is left the moment it hits 0.
  assign emit      = (state == ST_SHIFT) && (beat_words != '0) && icap_avail;
  assign rem_after = remaining - LEN_WIDTH'(4);

  // The end-of-beat decision is taken in the same cycle as the last word so
  // a full beat costs exactly BEAT_WORDS shift cycles plus its LOAD cycle.
  // A zero-word beat (tkeep all clear) decides immediately on remaining.
  assign rem_eval = (beat_words == '0) ? remaining : rem_after;
  assign end_beat = (state == ST_SHIFT) &&
                    ((beat_words == '0) || (emit && (beat_words == BW_W'(1))));
  assign overrun  = emit && (beat_words > BW_W'(1)) && (rem_after == '0);

  // Byte 0 goes to the most significant lane of the ICAP word.
  always_comb begin
    emit_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (BIT_SWAP) emit_word[31-8*i -: 8] = bit_rev8(shreg[8*i +: 8]);
      else          emit_word[31-8*i -: 8] = shreg[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      words      <= '0;
      err        <= ERR_OK;
      shreg      <= '0;
      beat_words <= '0;
      beat_last  <= 1'b0;
      icap_csib  <= 1'b1;
      icap_i     <= '0;
    end else begin
      // ICAP port: csib low exactly for the cycle after each emitted word;
      // icap_i holds its last value otherwise.
      icap_csib <= ~emit;
      if (emit) icap_i <= emit_word;

      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            remaining <= {s_cmd_len[LEN_WIDTH-1:2], 2'b00};
            words     <= '0;
            err       <= ERR_OK;
            state     <= (s_cmd_len[LEN_WIDTH-1:2] == '0) ? ST_DONE : ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (beat_fire) begin
            if (!keep_ok(keep_ext)) begin
              if (err == ERR_OK) err <= ERR_KEEP;
              state <= s_axis_tlast ? ST_DONE : ST_FLUSH;
            end else begin
              shreg      <= s_axis_tdata;
              beat_words <= BW_W'(keep_pc >> 2);
              beat_last  <= s_axis_tlast;
              state      <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          if (emit) begin
            shreg      <= shreg >> 32;
            words      <= words + SW_W'(1);
            remaining  <= rem_after;
            beat_words <= beat_words - BW_W'(1);
          end
          if (end_beat) begin
            if (beat_last) begin
              if ((rem_eval != '0) && (err == ERR_OK)) err <= ERR_SHORT;
              state <= ST_DONE;
            end else if (rem_eval == '0) begin
              // length satisfied but the transfer keeps going
              if (err == ERR_OK) err <= ERR_LONG;
              state <= ST_FLUSH;
            end else begin
              state <= ST_LOAD;
            end
          end else if (overrun) begin
            // commanded length reached mid-beat: drop the rest of the beat
            if (err == ERR_OK) err <= ERR_LONG;
            state <= beat_last ? ST_DONE : ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          if (beat_fire && s_axis_tlast) state <= ST_DONE;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icap_stream_writer.sv
module tb_icap_stream_writer;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int LW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] s_cmd_len;
  logic          s_cmd_valid;
  logic          s_cmd_ready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          icap_csib;
  logic          icap_rdwrb;
  logic [31:0]   icap_i;
  logic          icap_avail;
  logic [LW-3:0] m_status_words;
  logic [1:0]    m_status_error;
  logic          m_status_valid;
  logic          busy;

  always #5 clk = ~clk;

  icap_stream_writer #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW), .BIT_SWAP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s_cmd_len(s_cmd_len), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i), .icap_avail(icap_avail),
    .m_status_words(m_status_words), .m_status_error(m_status_error),
    .m_status_valid(m_status_valid), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // stimulus for one transfer
  logic [DW-1:0] bdata[$];
  logic [KW-1:0] bkeep[$];
  logic          blast[$];

  // reference model results
  logic [31:0]   exp_q[$];
  logic [31:0]   got_q[$];
  int            exp_err;
  int            exp_consumed;

  // timing observations of the last transfer (cycle indices)
  int t_cmd, t_first, t_last, t_stat;

  function automatic logic [KW-1:0] keep_mask(input int n);
    logic [KW-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  // ICAP word j of a beat: bytes 4j..4j+3, first byte most significant,
  // every byte bit-reversed.
  function automatic logic [31:0] word_of(input logic [DW-1:0] d, input int j);
    logic [7:0]  b, r;
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = d[8*(4*j+k) +: 8];
      r = {<<{b}};
      w[31-8*k -: 8] = r;
    end
    return w;
  endfunction

  // Walk the transfer in words: emit what the command still allows, note the
  // first rule violated, drain to tlast after any violation.
  task automatic compute_model(input int len);
    int rem, n, w, e;
    bit done;
    exp_q.delete();
    exp_err = 0;
    exp_consumed = 0;
    rem = len / 4;
    if (rem == 0) return;
    done = 0;
    for (int i = 0; i < bkeep.size() && !done; i++) begin
      exp_consumed = i + 1;
      if (exp_err != 0) begin
        if (blast[i]) done = 1;
      end else begin
        n = $countones(bkeep[i]);
        if ((n % 4) != 0 || bkeep[i] != keep_mask(n)) begin
          exp_err = 3;
          if (blast[i]) done = 1;
        end else begin
          w = n / 4;
          e = (w < rem) ? w : rem;
          for (int j = 0; j < e; j++) exp_q.push_back(word_of(bdata[i], j));
          if (w > rem) begin
            exp_err = 2;
            rem = 0;
            if (blast[i]) done = 1;
          end else begin
            rem -= w;
            if (blast[i]) begin
              if (rem > 0) exp_err = 1;
              done = 1;
            end else if (rem == 0) begin
              exp_err = 2;
            end
          end
        end
      end
    end
  endtask

  task automatic clear_beats();
    bdata.delete(); bkeep.delete(); blast.delete();
  endtask

  task automatic add_beat(input logic [KW-1:0] keep, input logic last);
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
    bdata.push_back(d); bkeep.push_back(keep); blast.push_back(last);
  endtask

  task automatic drive_beat(input int bi);
    if (bi < bdata.size()) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = bdata[bi];
      s_axis_tkeep  = bkeep[bi];
      s_axis_tlast  = blast[bi];
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = {16{$urandom}};
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  // Run one command against the current beat list. Called just after a
  // rising edge. The command stays valid (with junk length) after acceptance
  // until status, so a second accept would show up as an extra fire.
  task automatic run_txn(input string name, input int len, input int avail_pct);
    int bi, cyc, cmd_fires;
    bit got_status, cmd_f, beat_f, bad;
    logic [LW-3:0] st_words;
    logic [1:0]    st_err;
    compute_model(len);
    got_q.delete();
    bi = 0; cyc = 0; cmd_fires = 0; got_status = 0;
    t_cmd = -1; t_first = -1; t_last = -1; t_stat = -1;
    st_words = '0; st_err = '0;
    s_cmd_valid = 1'b1;
    s_cmd_len   = LW'(len);
    drive_beat(0);
    icap_avail = ($urandom_range(99) < avail_pct);
    while (!got_status && cyc < 3000) begin
      @(negedge clk);
      if (!icap_csib) begin
        got_q.push_back(icap_i);
        if (t_first < 0) t_first = cyc;
        t_last = cyc;
      end
      if (m_status_valid) begin
        got_status = 1; st_words = m_status_words; st_err = m_status_error; t_stat = cyc;
      end
      cmd_f  = s_cmd_valid && s_cmd_ready;
      beat_f = s_axis_tvalid && s_axis_tready;
      if (cmd_f) begin
        cmd_fires++;
        if (t_cmd < 0) t_cmd = cyc;
      end
      @(posedge clk); #1;
      if (cmd_f) s_cmd_len = LW'($urandom);
      if (beat_f) bi++;
      drive_beat(bi);
      icap_avail = ($urandom_range(99) < avail_pct);
      cyc++;
    end
    s_cmd_valid = 1'b0;
    s_axis_tvalid = 1'b0;
    icap_avail = 1'b1;

    vectors++;
    if (!got_status) begin
      miscompares++;
      $display("FAIL %s status_timeout: got no status pulse, required one within 3000 cycles", name);
    end
    vectors++;
    if (cmd_fires != 1) begin
      miscompares++;
      $display("FAIL %s cmd_accepts: got %0d, required 1", name, cmd_fires);
    end
    vectors++;
    bad = (got_q.size() != exp_q.size());
    for (int i = 0; i < got_q.size() && !bad; i++) begin
      if (got_q[i] !== exp_q[i]) begin
        bad = 1;
        $display("FAIL %s icap_word[%0d]: got %08h, required %08h", name, i, got_q[i], exp_q[i]);
      end
    end
    if (bad) begin
      miscompares++;
      if (got_q.size() != exp_q.size())
        $display("FAIL %s icap_word_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
    end
    vectors++;
    if (st_words !== (LW-2)'(exp_q.size())) begin
      miscompares++;
      $display("FAIL %s status_words: got %0d, required %0d", name, st_words, exp_q.size());
    end
    vectors++;
    if (st_err !== 2'(exp_err)) begin
      miscompares++;
      $display("FAIL %s status_error: got %0d, required %0d", name, st_err, exp_err);
    end
    vectors++;
    if (bi != exp_consumed) begin
      miscompares++;
      $display("FAIL %s beats_consumed: got %0d, required %0d", name, bi, exp_consumed);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_cmd_valid = 1'b0; s_cmd_len = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    icap_avail = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (s_cmd_ready !== 1'b0 || s_axis_tready !== 1'b0 || m_status_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_during: cmd_ready=%b tready=%b status_valid=%b, required 0 0 0",
               s_cmd_ready, s_axis_tready, m_status_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (icap_csib !== 1'b1 || icap_rdwrb !== 1'b0 || icap_i !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_icap: csib=%b rdwrb=%b i=%08h, required 1 0 00000000",
               icap_csib, icap_rdwrb, icap_i);
    end
    vectors++;
    if (s_cmd_ready !== 1'b1 || s_axis_tready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: cmd_ready=%b tready=%b busy=%b, required 1 0 0",
               s_cmd_ready, s_axis_tready, busy);
    end
    vectors++;
    if (m_status_valid !== 1'b0 || m_status_words !== '0 || m_status_error !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_status: valid=%b words=%0d err=%0d, required 0 0 0",
               m_status_valid, m_status_words, m_status_error);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_beat();
    clear_beats();
    add_beat('1, 1'b1);
    run_txn("full_beat", 64, 100);
    vectors++;
    if (t_first - t_cmd != 3) begin
      miscompares++;
      $display("FAIL full_beat_latency: got %0d cycles, required 3", t_first - t_cmd);
    end
    vectors++;
    if (t_last - t_first != 15) begin
      miscompares++;
      $display("FAIL full_beat_span: got %0d cycles, required 15", t_last - t_first);
    end
    vectors++;
    if (t_stat != t_last) begin
      miscompares++;
      $display("FAIL full_beat_status_time: got cycle %0d, required %0d", t_stat, t_last);
    end
  endtask

  task automatic test_back_to_back();
    clear_beats();
    add_beat('1, 1'b0);
    add_beat('1, 1'b1);
    run_txn("b2b_first", 128, 100);
    vectors++;
    if (t_last - t_first != 32) begin
      miscompares++;
      $display("FAIL b2b_throughput: got span %0d cycles, required 32", t_last - t_first);
    end
    clear_beats();
    add_beat(keep_mask(32), 1'b1);
    run_txn("b2b_second", 32, 100);
  endtask

  task automatic test_avail_toggle();
    clear_beats();
    add_beat('1, 1'b0);
    add_beat('1, 1'b1);
    run_txn("avail_toggle", 128, 50);
  endtask

  task automatic test_short();
    clear_beats();
    add_beat('1, 1'b1);
    run_txn("short", 128, 100);
  endtask

  task automatic test_long();
    clear_beats();
    add_beat('1, 1'b0);
    add_beat('1, 1'b1);
    run_txn("long", 32, 100);
  endtask

  task automatic test_bad_keep();
    clear_beats();
    add_beat(64'h7, 1'b0);
    add_beat('1, 1'b0);
    add_beat('1, 1'b1);
    run_txn("bad_keep", 64, 100);
  endtask

  task automatic test_partial_and_zero();
    clear_beats();
    add_beat(keep_mask(24), 1'b0);
    add_beat(keep_mask(16), 1'b1);
    run_txn("partial_keep", 41, 70);
    clear_beats();
    run_txn("zero_len", 3, 100);
  endtask

  task automatic test_reset_mid();
    int  cnt;
    bit  pulse;
    clear_beats();
    add_beat('1, 1'b0);
    add_beat('1, 1'b1);
    s_cmd_valid = 1'b1; s_cmd_len = LW'(256);
    drive_beat(0);
    icap_avail = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      s_cmd_valid = 1'b0;
      cnt++;
    end while (icap_csib !== 1'b0 && cnt < 20);
    vectors++;
    if (icap_csib !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_start: got csib=%b after 20 cycles, required 0", icap_csib);
    end
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (icap_csib !== 1'b1 || busy !== 1'b0 || s_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_abort: csib=%b busy=%b cmd_ready=%b, required 1 0 1",
               icap_csib, busy, s_cmd_ready);
    end
    pulse = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_status_valid) pulse = 1;
    end
    vectors++;
    if (pulse) begin
      miscompares++;
      $display("FAIL reset_mid_status: got a status pulse after reset, required none");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int len, nb, r;
    for (int t = 0; t < 40; t++) begin
      clear_beats();
      len = $urandom_range(0, 300);
      if (len >= 4) begin
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin
          r = $urandom_range(0, 9);
          if (r < 6)      add_beat('1, b == nb-1);
          else if (r < 9) add_beat(keep_mask(4*$urandom_range(0, 15)), b == nb-1);
          else            add_beat({$urandom, $urandom}, b == nb-1);
        end
      end
      run_txn($sformatf("random_%0d", t), len, $urandom_range(30, 100));
    end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_back_to_back();
    test_avail_toggle();
    test_short();
    test_long();
    test_bad_keep();
    test_partial_and_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
